// File: rtl/writeback.sv
// Writeback / retirement stage.
// Selects the register-file result, issues CSR writes, raises traps
// (interrupt has priority over exception), redirects on trap or mret and
// parks the pipeline in SLEEP after a retired wfi until an interrupt is
// pending.
// Optional feature: define WRITEBACK_INSTRET_EN to build the
// retired-instruction counter; otherwise instret is tied to zero.
module writeback #(
  parameter int unsigned INSTRET_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [31:0]              pc_in,
  input  logic [31:0]              next_pc_in,
  input  logic [31:0]              alu_data_in,
  input  logic [31:0]              csr_data_in,
  input  logic [31:0]              load_data_in,
  input  logic [1:0]               write_select_in,
  input  logic [4:0]               rd_address_in,
  input  logic [11:0]              csr_address_in,
  input  logic                     csr_write_in,
  input  logic                     mret_in,
  input  logic                     wfi_in,
  input  logic                     valid_in,
  input  logic                     exception_in,
  input  logic [3:0]               ecause_in,
  input  logic [31:0]              mtvec_in,
  input  logic [31:0]              mepc_in,
  input  logic                     interrupt_pending,
  output logic [4:0]               reg_write_address,
  output logic [31:0]              reg_write_data,
  output logic                     csr_write_enable,
  output logic [11:0]              csr_write_address,
  output logic [31:0]              csr_write_data,
  output logic                     trap,
  output logic                     trap_interrupt,
  output logic [3:0]               trap_cause,
  output logic [31:0]              trap_pc,
  output logic                     redirect,
  output logic [31:0]              redirect_address,
  output logic                     wfi_stall,
  output logic                     retire,
  output logic [INSTRET_WIDTH-1:0] instret
);

  typedef enum logic {
    RUN   = 1'b0,
    SLEEP = 1'b1
  } state_t;

  localparam logic [3:0] INT_CAUSE = 4'hB;

  state_t state, state_next;
  logic   take_int, take_exc, commit;

  // Qualify the incoming instruction; nothing is accepted while asleep.
  always_comb begin
    take_int = (state == RUN) && valid_in && interrupt_pending;
    take_exc = (state == RUN) && valid_in && exception_in && !take_int;
    commit   = (state == RUN) && valid_in && !exception_in && !take_int;
  end

  // State register; reset forces RUN so wfi_stall drops immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state: sleep after a retired wfi, wake on any pending interrupt.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (commit && wfi_in) state_next = SLEEP;
      SLEEP:   if (interrupt_pending) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Output decode, purely combinational from inputs and state.
  always_comb begin
    reg_write_address = commit ? rd_address_in : '0;
    case (write_select_in)
      2'b00:   reg_write_data = alu_data_in;
      2'b01:   reg_write_data = csr_data_in;
      2'b10:   reg_write_data = load_data_in;
      default: reg_write_data = next_pc_in;
    endcase

    csr_write_enable  = commit && csr_write_in;
    csr_write_address = csr_address_in;
    csr_write_data    = alu_data_in;

    trap           = take_int || take_exc;
    trap_interrupt = take_int;
    trap_cause     = take_int ? INT_CAUSE : ecause_in;
    trap_pc        = pc_in;

    redirect         = trap || (commit && mret_in);
    redirect_address = trap ? {mtvec_in[31:2], 2'b00} : mepc_in;

    wfi_stall = (state == SLEEP);
    retire    = commit;
  end

`ifdef WRITEBACK_INSTRET_EN
  // Retired-instruction counter; wraps naturally at all-ones.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      instret <= '0;
    end else if (commit) begin
      instret <= instret + INSTRET_WIDTH'(1);
    end
  end
`else
  assign instret = '0;
`endif

endmodule
